// File: rtl/mdu_if.sv
// mdu_if: EX-stage request and HI/LO result bundle for the multiply/divide unit
interface mdu_if;
    logic        valid;
    logic        flush;
    logic [4:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output valid, flush, alucontrol, a, b, input stall, result, hi, lo);
    modport slave  (input valid, flush, alucontrol, a, b, output stall, result, hi, lo);
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: HI/LO register file with single-cycle multiply and 32-iteration restoring divider
module mdu_hilo (
    input logic clk,
    input logic rst,
    mdu_if.slave m
);
    localparam logic [4:0] ALU_MULT  = 5'd16;
    localparam logic [4:0] ALU_MULTU = 5'd17;
    localparam logic [4:0] ALU_DIV   = 5'd18;
    localparam logic [4:0] ALU_DIVU  = 5'd19;
    localparam logic [4:0] ALU_MFHI  = 5'd20;
    localparam logic [4:0] ALU_MFLO  = 5'd21;
    localparam logic [4:0] ALU_MTHI  = 5'd22;
    localparam logic [4:0] ALU_MTLO  = 5'd23;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      st;
    logic [4:0]  cnt;
    logic [31:0] hi, lo, quo, rem, dvs;
    logic        nq, nr;
    logic        acc, is_div, sg;
    logic [32:0] t;
    logic signed [63:0] ps;
    logic [63:0] pu;

    assign acc    = m.valid & ~m.flush;
    assign sg     = m.alucontrol == ALU_DIV;
    assign is_div = sg | (m.alucontrol == ALU_DIVU);
    assign ps     = $signed(m.a) * $signed(m.b);
    assign pu     = {32'b0, m.a} * {32'b0, m.b};
    assign t      = {1'b0, rem[30:0], quo[31]} - {1'b0, dvs};

    assign m.hi     = hi;
    assign m.lo     = lo;
    assign m.stall  = ~rst & ((st == IDLE & acc & is_div) | (st == BUSY & ~m.flush));
    assign m.result = m.alucontrol == ALU_MFHI ? hi : m.alucontrol == ALU_MFLO ? lo : 32'd0;

    // FSM, divider datapath and HI/LO commits
    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= IDLE;
            cnt <= 5'd0;
            hi  <= 32'd0;
            lo  <= 32'd0;
            quo <= 32'd0;
            rem <= 32'd0;
            dvs <= 32'd0;
            nq  <= 1'b0;
            nr  <= 1'b0;
        end else begin
            case (st)
                IDLE: if (acc) begin
                    if (m.alucontrol == ALU_MULT) {hi, lo} <= ps;
                    if (m.alucontrol == ALU_MULTU) {hi, lo} <= pu;
                    if (m.alucontrol == ALU_MTHI) hi <= m.a;
                    if (m.alucontrol == ALU_MTLO) lo <= m.a;
                    if (is_div) begin
                        quo <= (sg & m.a[31]) ? -m.a : m.a;
                        dvs <= (sg & m.b[31]) ? -m.b : m.b;
                        rem <= 32'd0;
                        cnt <= 5'd0;
                        nq  <= sg & (m.a[31] ^ m.b[31]);
                        nr  <= sg & m.a[31];
                        st  <= BUSY;
                    end
                end
                BUSY: if (m.flush) st <= IDLE;
                else begin
                    rem <= t[32] ? {rem[30:0], quo[31]} : t[31:0];
                    quo <= {quo[30:0], ~t[32]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) st <= DONE;
                end
                DONE: begin
                    st <= IDLE;
                    if (!m.flush) begin
                        lo <= nq ? -quo : quo;
                        hi <= nr ? -rem : rem;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: randomized self-checking bench against an arithmetic HI/LO model
module tb_mdu_hilo;
    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_MULT  = 5'd16;
    localparam logic [4:0] ALU_MULTU = 5'd17;
    localparam logic [4:0] ALU_DIV   = 5'd18;
    localparam logic [4:0] ALU_DIVU  = 5'd19;
    localparam logic [4:0] ALU_MFHI  = 5'd20;
    localparam logic [4:0] ALU_MFLO  = 5'd21;
    localparam logic [4:0] ALU_MTHI  = 5'd22;
    localparam logic [4:0] ALU_MTLO  = 5'd23;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_if bus();
    mdu_hilo dut (.clk(clk), .rst(rst), .m(bus));

    int ncmp = 0;
    int nerr = 0;
    logic [31:0] mhi, mlo;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return sg ? {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)} : {a, 32'hFFFFFFFF};
        sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [63:0] ref_mul(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = sg ? longint'($signed(a)) * longint'($signed(b)) : longint'({32'b0, a}) * longint'({32'b0, b});
        return p;
    endfunction

    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b, input string nm);
        int n;
        bus.valid = 1'b1;
        bus.flush = 1'b0;
        bus.alucontrol = sg ? ALU_DIV : ALU_DIVU;
        bus.a = a;
        bus.b = b;
        #1;
        n = 0;
        while (bus.stall && n < 100) begin
            n++;
            tick();
        end
        tick();
        bus.valid = 1'b0;
        {mhi, mlo} = ref_div(sg, a, b);
        ncmp++;
        if (n !== 33) begin nerr++; $display("FAIL %s stall_cycles got %0d want 33", nm, n); end
        ncmp++;
        if (bus.lo !== mlo) begin nerr++; $display("FAIL %s lo got %h want %h", nm, bus.lo, mlo); end
        ncmp++;
        if (bus.hi !== mhi) begin nerr++; $display("FAIL %s hi got %h want %h", nm, bus.hi, mhi); end
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string nm);
        bus.valid = 1'b1;
        bus.flush = 1'b0;
        bus.alucontrol = op;
        bus.a = a;
        bus.b = b;
        #1;
        ncmp++;
        if (bus.stall !== 1'b0) begin nerr++; $display("FAIL %s stall got %b want 0", nm, bus.stall); end
        tick();
        bus.valid = 1'b0;
        if (op == ALU_MULT || op == ALU_MULTU) {mhi, mlo} = ref_mul(op == ALU_MULT, a, b);
        if (op == ALU_MTHI) mhi = a;
        if (op == ALU_MTLO) mlo = a;
        ncmp++;
        if ({bus.hi, bus.lo} !== {mhi, mlo}) begin nerr++; $display("FAIL %s hilo got %h_%h want %h_%h", nm, bus.hi, bus.lo, mhi, mlo); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid = 1'b1;
        bus.flush = 1'b0;
        bus.alucontrol = ALU_DIV;
        bus.a = 32'd5;
        bus.b = 32'd3;
        tick();
        tick();
        ncmp++;
        if (bus.stall !== 1'b0) begin nerr++; $display("FAIL reset_stall got %b want 0", bus.stall); end
        ncmp++;
        if ({bus.hi, bus.lo} !== 64'd0) begin nerr++; $display("FAIL reset_hilo got %h_%h want 0", bus.hi, bus.lo); end
        bus.valid = 1'b0;
        rst = 1'b0;
        mhi = 32'd0;
        mlo = 32'd0;
        tick();
    endtask

    task automatic test_mult();
        run_op(ALU_MULT, 32'hFFFFFFFF, 32'd2, "mult_fixed");
        ncmp++;
        if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFE) begin nerr++; $display("FAIL mult_const got %h_%h", bus.hi, bus.lo); end
        run_op(ALU_MULTU, 32'hFFFFFFFF, 32'd2, "multu_fixed");
        ncmp++;
        if ({bus.hi, bus.lo} !== 64'h00000001_FFFFFFFE) begin nerr++; $display("FAIL multu_const got %h_%h", bus.hi, bus.lo); end
        for (int i = 0; i < 8; i++) run_op(i[0] ? ALU_MULTU : ALU_MULT, $urandom, $urandom, "mult_rand");
        run_op(ALU_MTHI, $urandom, 32'd0, "mthi_rand");
        run_op(ALU_MTLO, $urandom, 32'd0, "mtlo_rand");
    endtask

    task automatic test_mf();
        bus.valid = 1'b1;
        bus.alucontrol = ALU_MFLO;
        #1;
        ncmp++;
        if (bus.result !== mlo) begin nerr++; $display("FAIL mflo got %h want %h", bus.result, mlo); end
        bus.alucontrol = ALU_MFHI;
        #1;
        ncmp++;
        if (bus.result !== mhi) begin nerr++; $display("FAIL mfhi got %h want %h", bus.result, mhi); end
        tick();
        bus.valid = 1'b0;
    endtask

    task automatic test_div_fixed();
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, "div_m7_2");
        ncmp++;
        if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFD) begin nerr++; $display("FAIL div_m7_const got %h_%h", bus.hi, bus.lo); end
        test_mf();
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        ncmp++;
        if ({bus.hi, bus.lo} !== 64'h00000000_80000000) begin nerr++; $display("FAIL div_ovf_const got %h_%h", bus.hi, bus.lo); end
        run_div(1'b0, 32'h00001234, 32'd0, "divu_zero");
        ncmp++;
        if ({bus.hi, bus.lo} !== 64'h00001234_FFFFFFFF) begin nerr++; $display("FAIL divu_zero_const got %h_%h", bus.hi, bus.lo); end
        run_div(1'b1, 32'hFFFFFF00, 32'd0, "div_zero_neg");
        run_div(1'b1, 32'd77, 32'd0, "div_zero_pos");
    endtask

    task automatic test_div_rand();
        for (int i = 0; i < 8; i++) run_div(i[0], $urandom, (i == 3) ? 32'd1 + $urandom_range(0, 15) : $urandom, "div_rand");
        test_mf();
    endtask

    task automatic test_flush();
        run_op(ALU_MTHI, 32'hDEADBEEF, 32'd0, "mthi_fixed");
        bus.valid = 1'b1;
        bus.alucontrol = ALU_DIVU;
        bus.a = 32'd100;
        bus.b = 32'd7;
        #1;
        for (int i = 0; i < 11; i++) tick();
        bus.flush = 1'b1;
        #1;
        ncmp++;
        if (bus.stall !== 1'b0) begin nerr++; $display("FAIL flush_busy_stall got %b want 0", bus.stall); end
        tick();
        bus.flush = 1'b0;
        bus.valid = 1'b0;
        ncmp++;
        if ({bus.hi, bus.lo} !== {32'hDEADBEEF, mlo}) begin nerr++; $display("FAIL flush_busy_hilo got %h_%h want %h_%h", bus.hi, bus.lo, 32'hDEADBEEF, mlo); end
        run_div(1'b0, 32'd100, 32'd7, "divu_after_flush");
        ncmp++;
        if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin nerr++; $display("FAIL divu_100_7 got %h_%h want 2_14", bus.hi, bus.lo); end
        bus.valid = 1'b1;
        bus.flush = 1'b1;
        bus.alucontrol = ALU_MULT;
        bus.a = $urandom;
        bus.b = $urandom;
        tick();
        bus.alucontrol = ALU_DIV;
        #1;
        ncmp++;
        if (bus.stall !== 1'b0) begin nerr++; $display("FAIL flush_accept_stall got %b want 0", bus.stall); end
        tick();
        bus.flush = 1'b0;
        bus.valid = 1'b0;
        tick();
        ncmp++;
        if ({bus.hi, bus.lo} !== {mhi, mlo} || bus.stall !== 1'b0) begin nerr++; $display("FAIL flush_accept_hilo got %h_%h want %h_%h", bus.hi, bus.lo, mhi, mlo); end
        run_div(1'b1, $urandom, $urandom, "div_after_flush");
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom_range(1, 1000);
        bus.valid = 1'b1;
        bus.alucontrol = ALU_DIV;
        bus.a = a;
        bus.b = b;
        #1;
        for (int i = 0; i < 21; i++) tick();
        rst = 1'b1;
        #1;
        ncmp++;
        if (bus.stall !== 1'b0) begin nerr++; $display("FAIL reset_mid_stall got %b want 0", bus.stall); end
        tick();
        rst = 1'b0;
        mhi = 32'd0;
        mlo = 32'd0;
        ncmp++;
        if ({bus.hi, bus.lo} !== 64'd0) begin nerr++; $display("FAIL reset_mid_hilo got %h_%h want 0", bus.hi, bus.lo); end
        run_div(1'b1, a, b, "div_after_reset");
    endtask

    task automatic test_nonmdu();
        for (int i = 0; i < 10; i++) begin
            bus.valid = 1'b1;
            bus.alucontrol = i[0] ? ALU_AND : ALU_ADD;
            bus.a = $urandom;
            bus.b = $urandom;
            #1;
            ncmp++;
            if (bus.stall !== 1'b0 || bus.result !== 32'd0) begin nerr++; $display("FAIL nonmdu_out stall %b result %h want 0 0", bus.stall, bus.result); end
            tick();
            ncmp++;
            if ({bus.hi, bus.lo} !== {mhi, mlo}) begin nerr++; $display("FAIL nonmdu_hilo got %h_%h want %h_%h", bus.hi, bus.lo, mhi, mlo); end
        end
        bus.valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 3))
                0: run_op(ALU_MULT, $urandom, $urandom, "b2b_mult");
                1: run_op(ALU_MTLO, $urandom, 32'd0, "b2b_mtlo");
                2: run_div(1'b1, $urandom, $urandom_range(0, 9), "b2b_div");
                default: run_div(1'b0, $urandom, $urandom, "b2b_divu");
            endcase
        end
        test_mf();
    endtask

    initial begin
        bus.valid = 1'b0;
        bus.flush = 1'b0;
        bus.alucontrol = ALU_ADD;
        bus.a = 32'd0;
        bus.b = 32'd0;
        rst = 1'b1;
        test_reset();
        test_mult();
        test_mf();
        test_div_fixed();
        test_div_rand();
        test_flush();
        test_reset_mid();
        test_nonmdu();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
